// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the system PLL in reset, waits for a stable lock,
// then releases the core and peripheral resets in stages. Runs on the board
// reference clock, so it keeps running while the PLL is unlocked.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 8,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_DELAY        = 16,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned CNT_W              = 17
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       periph_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int unsigned RC_W = 8;

  typedef enum logic [2:0] {
    ST_PLL_RESET    = 3'd0,
    ST_WAIT_LOCK    = 3'd1,
    ST_STABLE       = 3'd2,
    ST_RELEASE_CORE = 3'd3,
    ST_RUN          = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    lk;
  logic                    pll_rst_q, pll_rst_d;
  logic                    core_q, core_d;
  logic                    periph_q, periph_d;
  logic                    ready_q, ready_d;
  logic                    lost_q, lost_d;
  logic [RC_W-1:0]         retry_q, retry_d;

  // Synchronise the asynchronous lock flag into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PLL_RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      core_q    <= 1'b0;
      periph_q  <= 1'b0;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      core_q    <= core_d;
      periph_q  <= periph_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
      retry_q   <= retry_d;
    end
  end

  // Next-state and next-output logic; any abort lands in PLL_RESET with all resets asserted
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    pll_rst_d = pll_rst_q;
    core_d    = core_q;
    periph_d  = periph_q;
    ready_d   = ready_q;
    lost_d    = lost_q;
    retry_d   = retry_q;

    if (sw_reset_req) begin
      // Software request wins over lock status and pins the counter at zero
      state_d   = ST_PLL_RESET;
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      core_d    = 1'b0;
      periph_d  = 1'b0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        ST_PLL_RESET: begin
          pll_rst_d = 1'b1;
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_d   = ST_WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state_d   = ST_PLL_RESET;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_q != {RC_W{1'b1}}) begin
              retry_d = retry_q + RC_W'(1);
            end
          end
        end
        ST_STABLE: begin
          if (!lk) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES)) begin
            state_d = ST_RELEASE_CORE;
            cnt_d   = '0;
            core_d  = 1'b1;
          end
        end
        ST_RELEASE_CORE, ST_RUN: begin
          if (!lk) begin
            state_d   = ST_PLL_RESET;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            core_d    = 1'b0;
            periph_d  = 1'b0;
            ready_d   = 1'b0;
            lost_d    = 1'b1;
          end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q;
          end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            periph_d = 1'b1;
            ready_d  = 1'b1;
          end
        end
        default: begin
          state_d   = ST_PLL_RESET;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          core_d    = 1'b0;
          periph_d  = 1'b0;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  assign pll_rst        = pll_rst_q;
  assign core_reset_n   = core_q;
  assign periph_reset_n = periph_q;
  assign ready          = ready_q;
  assign lock_lost      = lost_q;
  assign retry_count    = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output changes (cycle, value)
// are queued by the stimulus; a monitor pops one per observed output change.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_rst, core_reset_n, periph_reset_n, ready, lock_lost;
  logic [7:0] retry_count;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(3), .LOCK_STABLE_CYCLES(8),
    .STAGE_DELAY(4), .LOCK_TIMEOUT(32), .CNT_W(17)
  ) dut (
    .clk(clk), .reset_n(reset_n), .locked(locked), .sw_reset_req(sw_reset_req),
    .pll_rst(pll_rst), .core_reset_n(core_reset_n), .periph_reset_n(periph_reset_n),
    .ready(ready), .lock_lost(lock_lost), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [12:0] v;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          base = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic [12:0] prev, cur;
  exp_t        e;
  wire  [12:0] outs = {pll_rst, core_reset_n, periph_reset_n, ready, lock_lost, retry_count};

  function automatic logic [12:0] mk(input logic p, input logic c, input logic ph,
                                     input logic r, input logic ll, input logic [7:0] rc);
    return {p, c, ph, r, ll, rc};
  endfunction

  localparam logic [12:0] RST_V = 13'h1000;

  always @(posedge clk) cyc++;

  // Monitor: every output change must match the head of the expectation queue
  always @(negedge clk) begin
    if (mon_en) begin
      cur = outs;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missed_event: expected %h at cycle %0d, outputs now %h at cycle %0d",
                 q[0].v, q[0].cyc - base, cur, cyc - base);
        void'(q.pop_front());
      end
      if (cur !== prev) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: outputs %h at edge %0d, nothing expected", cur, cyc - base);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.v !== cur) begin
            n_bad++;
            $display("FAIL output_change: got %h at edge %0d, expected %h at edge %0d",
                     cur, cyc - base, e.v, e.cyc - base);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic drained(input string nm);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never seen, next %h at edge %0d",
               nm, q.size(), q[0].v, q[0].cyc - base);
      q.delete();
    end
  endtask

  task automatic push(input int k, input logic [12:0] v);
    q.push_back('{cyc: base + k, v: v});
  endtask

  // Returns at the negedge following edge k
  task automatic run_to(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic release_rst();
    reset_n = 1'b1;
    base    = cyc + 1;
    prev    = outs;
    mon_en  = 1'b1;
  endtask

  task automatic do_reset(input logic lk_val);
    @(negedge clk);
    mon_en       = 1'b0;
    reset_n      = 1'b0;
    locked       = lk_val;
    sw_reset_req = 1'b0;
    #1 check("reset_state", outs, RST_V);
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);

    // Normal bring-up, lock arrives at edge 10
    do_reset(1'b0);
    push(2,  mk(0, 0, 0, 0, 0, 8'd0));
    push(21, mk(0, 1, 0, 0, 0, 8'd0));
    push(25, mk(0, 1, 1, 1, 0, 8'd0));
    run_to(9);  locked = 1'b1;
    run_to(30);
    drained("bringup");

    // One-cycle software request in RUN re-sequences without touching lock_lost
    sw_reset_req = 1'b1;
    push(31, mk(1, 0, 0, 0, 0, 8'd0));
    push(34, mk(0, 0, 0, 0, 0, 8'd0));
    push(44, mk(0, 1, 0, 0, 0, 8'd0));
    push(48, mk(0, 1, 1, 1, 0, 8'd0));
    run_to(31); sw_reset_req = 1'b0;
    run_to(55);
    drained("sw_reset");

    // Lock loss in RUN, then re-lock
    locked = 1'b0;
    push(58, mk(1, 0, 0, 0, 1, 8'd0));
    push(61, mk(0, 0, 0, 0, 1, 8'd0));
    push(81, mk(0, 1, 0, 0, 1, 8'd0));
    push(85, mk(0, 1, 1, 1, 1, 8'd0));
    run_to(69); locked = 1'b1;
    run_to(95);
    drained("lock_loss");

    // One-cycle lock glitch after 5 stable cycles restarts the stability count
    do_reset(1'b0);
    push(2,  mk(0, 0, 0, 0, 0, 8'd0));
    push(28, mk(0, 1, 0, 0, 0, 8'd0));
    push(32, mk(0, 1, 1, 1, 0, 8'd0));
    run_to(9);  locked = 1'b1;
    run_to(15); locked = 1'b0;
    run_to(16); locked = 1'b1;
    run_to(40);
    drained("lock_glitch");

    // Asynchronous reset in the middle of STABLE
    do_reset(1'b0);
    push(2, mk(0, 0, 0, 0, 0, 8'd0));
    run_to(9);  locked = 1'b1;
    run_to(15);
    drained("pre_async");
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1 check("async_reset_immediate", outs, RST_V);
    @(posedge clk);
    #1 check("async_reset_held", outs, RST_V);
    @(negedge clk);
    release_rst();
    push(2,  mk(0, 0, 0, 0, 0, 8'd0));
    push(12, mk(0, 1, 0, 0, 0, 8'd0));
    push(16, mk(0, 1, 1, 1, 0, 8'd0));
    run_to(25);
    drained("after_async");

    // No lock at all: 300 timeouts, retry_count saturates at 255
    do_reset(1'b0);
    push(2, mk(0, 0, 0, 0, 0, 8'd0));
    for (int n = 1; n <= 300; n++) begin
      logic [7:0] rc;
      rc = (n > 255) ? 8'd255 : 8'(n);
      push(34 + 35 * (n - 1), mk(1, 0, 0, 0, 0, rc));
      push(37 + 35 * (n - 1), mk(0, 0, 0, 0, 0, rc));
    end
    run_to(37 + 35 * 299 + 5);
    drained("timeouts");
    check("retry_saturated", outs, mk(0, 0, 0, 0, 0, 8'd255));

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
